// File: rtl/l1_l2_arbiter.sv
// Shares one unified-L2 port between the L1 I-cache and D-cache: grants one
// requester, drives L2 from a latched copy of its request, routes the response back.
module l1_l2_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 128,
  parameter int FIXED_PRIORITY = 0,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_addr,
  output logic [DATA_WIDTH-1:0] l2_wdata,
  input  logic [DATA_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp,
  output logic [CNT_WIDTH-1:0]  i_wait_cnt,
  output logic [CNT_WIDTH-1:0]  d_wait_cnt,
  output logic [1:0]            dbg_state_o
);

  // Handshake: L1 requests are levels held until their one-cycle resp pulse; the
  // L2 strobe is held from the cycle after the grant until the cycle l2_resp is high.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state_q;
  logic                  last_d_q;
  logic                  l2_read_q;
  logic                  l2_write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CNT_WIDTH-1:0]  i_wait_q, i_wait_d;
  logic [CNT_WIDTH-1:0]  d_wait_q, d_wait_d;
  logic                  d_req;
  logic                  grant_d;
  logic                  i_wait_inc;
  logic                  d_wait_inc;

  assign d_req   = d_read | d_write;
  // On a conflict the D-cache wins when fixed priority is set or the I-cache went last.
  assign grant_d = d_req & (~i_read | (FIXED_PRIORITY != 0) | ~last_d_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_d_q   <= 1'b0;
      l2_read_q  <= 1'b0;
      l2_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_read || d_req) begin
            state_q    <= grant_d ? SERVE_D : SERVE_I;
            last_d_q   <= grant_d;
            addr_q     <= grant_d ? d_addr : i_addr;
            wdata_q    <= grant_d ? d_wdata : '0;
            l2_write_q <= grant_d & d_write;
            l2_read_q  <= ~(grant_d & d_write);
          end
        end
        SERVE_I, SERVE_D: begin
          if (l2_resp) begin
            state_q    <= DONE;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The DONE bubble still belongs to the previous winner for wait accounting.
  assign i_wait_inc = i_read & ((state_q == SERVE_D) | ((state_q == DONE) & last_d_q));
  assign d_wait_inc = d_req & ((state_q == SERVE_I) | ((state_q == DONE) & ~last_d_q));
  assign i_wait_d   = (i_wait_inc && !(&i_wait_q)) ? i_wait_q + CNT_WIDTH'(1) : i_wait_q;
  assign d_wait_d   = (d_wait_inc && !(&d_wait_q)) ? d_wait_q + CNT_WIDTH'(1) : d_wait_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_wait_q <= '0;
      d_wait_q <= '0;
    end else begin
      i_wait_q <= i_wait_d;
      d_wait_q <= d_wait_d;
    end
  end

  assign i_resp      = l2_resp & (state_q == SERVE_I);
  assign d_resp      = l2_resp & (state_q == SERVE_D);
  assign i_rdata     = i_resp ? l2_rdata : '0;
  assign d_rdata     = d_resp ? l2_rdata : '0;
  assign l2_read     = l2_read_q;
  assign l2_write    = l2_write_q;
  assign l2_addr     = addr_q;
  assign l2_wdata    = wdata_q;
  assign i_wait_cnt  = i_wait_q;
  assign d_wait_cnt  = d_wait_q;
  assign dbg_state_o = state_q;

endmodule
